// File: rtl/a_ctrls_pkg.sv
`default_nettype none
// ============================================================================
// Module   : a_ctrls_pkg
// Brief    : Shared constants and state type for the a_ctrls poll scheduler
//            and the a_ctrls reply decoder.
// Revision : 1.0 - initial release
// ============================================================================
package a_ctrls_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SEND_R      = 3'd1,
        ST_SEND_NL     = 3'd2,
        ST_HDR         = 3'd3,
        ST_BODY        = 3'd4,
        ST_DONE        = 3'd5,
        ST_WAIT_PERIOD = 3'd6
    } state_t;

    localparam logic [31:0] HDR_STR          = "MEAS";
    localparam logic [7:0]  REQ_BYTE0        = 8'h52;
    localparam logic [7:0]  REQ_BYTE1        = 8'h0A;
    localparam int          BODY_LEN_DEFAULT = 23;

    // Header byte at match position idx (0 = first character).
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = HDR_STR[31:24];
            2'd1:    b = HDR_STR[23:16];
            2'd2:    b = HDR_STR[15:8];
            default: b = HDR_STR[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/a_ctrls_poll_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : a_ctrls_poll_sched_if
// Brief    : Control, UART TX/RX snoop and status bundle of the poll scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface a_ctrls_poll_sched_if;
    logic       enable;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_done;
    logic       timeout_err;
    logic [7:0] err_cnt;

    modport master (
        input  enable, tx_ready, rx_data, rx_valid,
        output tx_data, tx_valid, busy, frame_done, timeout_err, err_cnt
    );

    modport slave (
        output enable, tx_ready, rx_data, rx_valid,
        input  tx_data, tx_valid, busy, frame_done, timeout_err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/a_ctrls_hdr_match.sv
`default_nettype none
// ============================================================================
// Module   : a_ctrls_hdr_match
// Brief    : Streaming "MEAS" matcher; hit pulses combinationally on the 'S'.
// Revision : 1.0 - initial release
// ============================================================================
module a_ctrls_hdr_match
    import a_ctrls_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic [7:0] rx_data,
    input  wire logic       rx_valid,
    input  wire logic       clear,
    output logic            hit
);
    logic [1:0] r_idx;
    logic [7:0] w_exp;

    assign w_exp = hdr_byte(r_idx);
    assign hit   = rx_valid && !clear && (r_idx == 2'd3) && (rx_data == w_exp);

    // A stray 'M' can itself start a new header, so it restarts at index 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= 2'd0;
        end else if (clear || hit) begin
            r_idx <= 2'd0;
        end else if (rx_valid) begin
            if (rx_data == w_exp)
                r_idx <= r_idx + 2'd1;
            else if (rx_data == HDR_STR[31:24])
                r_idx <= 2'd1;
            else
                r_idx <= 2'd0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/a_ctrls_poll_sched.sv
`default_nettype none
// ============================================================================
// Module   : a_ctrls_poll_sched
// Brief    : Sends "R\n" every POLL_PERIOD cycles and tracks the MEAS reply.
//            Define A_CTRLS_RETRY_EN to re-request up to MAX_RETRY times.
// Revision : 1.0 - initial release
// ============================================================================
module a_ctrls_poll_sched
    import a_ctrls_pkg::*;
#(
    parameter int POLL_PERIOD = 100_000,
    parameter int TIMEOUT     = 50_000,
    parameter int BODY_LEN    = BODY_LEN_DEFAULT,
    parameter int MAX_RETRY   = 2
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    a_ctrls_poll_sched_if.master bus
);
    localparam int c_PW = $clog2(POLL_PERIOD);
    localparam int c_TW = $clog2(TIMEOUT + 1);
    localparam int c_BW = $clog2(BODY_LEN + 1);
    localparam logic [c_PW-1:0] c_period_end = c_PW'(POLL_PERIOD - 1);
    localparam logic [c_TW-1:0] c_tmo_end    = c_TW'(TIMEOUT - 1);
    localparam logic [c_BW-1:0] c_body_end   = c_BW'(BODY_LEN - 1);

    state_t          r_state, w_next;
    logic [c_PW-1:0] r_period;
    logic [c_TW-1:0] r_tmo;
    logic [c_BW-1:0] r_body;
    logic            r_timeout_err;
    logic [7:0]      r_err_cnt;

    logic       w_hit, w_in_rx, w_tmo_hit, w_body_last, w_enter_send_r;
    logic       w_retry_allowed, w_tmo_final;
    logic       w_tx_valid, w_busy, w_frame_done;
    logic [7:0] w_tx_data;

    a_ctrls_hdr_match u_hdr_match (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_data  (bus.rx_data),
        .rx_valid (bus.rx_valid),
        .clear    (r_state != ST_HDR),
        .hit      (w_hit)
    );

    assign w_in_rx        = (r_state == ST_HDR) || (r_state == ST_BODY);
    assign w_tmo_hit      = w_in_rx && (r_tmo == c_tmo_end);
    assign w_body_last    = (r_state == ST_BODY) && bus.rx_valid && (r_body == c_body_end);
    assign w_enter_send_r = (r_state != ST_SEND_R) && (w_next == ST_SEND_R);
    assign w_tmo_final    = w_tmo_hit && !w_retry_allowed;

`ifdef A_CTRLS_RETRY_EN
    localparam int c_RW = $clog2(MAX_RETRY + 1) + 1;
    logic [c_RW-1:0] r_retry;

    assign w_retry_allowed = (r_retry < c_RW'(MAX_RETRY));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_retry <= '0;
        else if (w_enter_send_r && ((r_state == ST_IDLE) || (r_state == ST_WAIT_PERIOD)))
            r_retry <= '0;
        else if (w_tmo_hit && w_retry_allowed)
            r_retry <= r_retry + c_RW'(1);
    end
`else
    // Retries compiled out: folds to 0 for any legal MAX_RETRY.
    assign w_retry_allowed = (MAX_RETRY < 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_tx_valid   = 1'b0;
        w_tx_data    = 8'h00;
        w_busy       = 1'b1;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.enable) w_next = ST_SEND_R;
            end
            ST_SEND_R: begin
                w_tx_valid = 1'b1;
                w_tx_data  = REQ_BYTE0;
                if (bus.tx_ready) w_next = ST_SEND_NL;
            end
            ST_SEND_NL: begin
                w_tx_valid = 1'b1;
                w_tx_data  = REQ_BYTE1;
                if (bus.tx_ready) w_next = ST_HDR;
            end
            ST_HDR, ST_BODY: begin
                // Timeout wins over a byte arriving in the same cycle.
                if (w_tmo_hit)
                    w_next = w_retry_allowed ? ST_SEND_R : ST_WAIT_PERIOD;
                else if ((r_state == ST_HDR) && w_hit)
                    w_next = ST_BODY;
                else if (w_body_last)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                w_frame_done = 1'b1;
                w_next       = ST_WAIT_PERIOD;
            end
            ST_WAIT_PERIOD: begin
                w_busy = 1'b0;
                if (r_period == c_period_end)
                    w_next = bus.enable ? ST_SEND_R : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period      <= '0;
            r_tmo         <= '0;
            r_body        <= '0;
            r_timeout_err <= 1'b0;
            r_err_cnt     <= 8'h00;
        end else begin
            if (w_enter_send_r)
                r_period <= '0;
            else if (r_period != c_period_end)
                r_period <= r_period + c_PW'(1);

            if (r_state == ST_SEND_NL)
                r_tmo <= '0;
            else if (w_in_rx)
                r_tmo <= r_tmo + c_TW'(1);

            if (r_state != ST_BODY)
                r_body <= '0;
            else if (bus.rx_valid)
                r_body <= r_body + c_BW'(1);

            r_timeout_err <= w_tmo_final;
            if (w_tmo_final && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.tx_valid    = w_tx_valid;
    assign bus.tx_data     = w_tx_data;
    assign bus.busy        = w_busy;
    assign bus.frame_done  = w_frame_done;
    assign bus.timeout_err = r_timeout_err;
    assign bus.err_cnt     = r_err_cnt;
endmodule
`default_nettype wire

// File: tb/tb_a_ctrls_poll_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_a_ctrls_poll_sched
// Brief    : Self-checking bench for a_ctrls_poll_sched (table, corner, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_a_ctrls_poll_sched;
    localparam int POLL_PERIOD = 200;
    localparam int TIMEOUT     = 100;
    localparam int BODY_LEN    = 23;
    localparam int MAX_RETRY   = 2;
`ifdef A_CTRLS_RETRY_EN
    localparam int N_RETRY = MAX_RETRY;
`else
    localparam int N_RETRY = 0;
`endif

    typedef struct {
        string pat;
        bit    done;
    } hdr_vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_mis   = 0;
    int   exp_err = 0;

    a_ctrls_poll_sched_if bus();

    a_ctrls_poll_sched #(
        .POLL_PERIOD (POLL_PERIOD),
        .TIMEOUT     (TIMEOUT),
        .BODY_LEN    (BODY_LEN),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Reference: the first "MEAS" substring opens the frame, BODY_LEN more
    // bytes close it, and the closing byte must land before cycle TIMEOUT-1.
    function automatic int model_done(input logic [7:0] b[$], input int co[$]);
        for (int k = 3; k < b.size(); k++) begin
            if (b[k-3] == 8'h4D && b[k-2] == 8'h45 && b[k-1] == 8'h41 && b[k] == 8'h53) begin
                if (k + BODY_LEN >= b.size()) return -1;
                if (co[k+BODY_LEN] > TIMEOUT - 2) return -1;
                return co[k+BODY_LEN] + 1;
            end
        end
        return -1;
    endfunction

    task automatic sched(input int n, input int max_gap, output int co[$]);
        int c = 0;
        co = {};
        for (int i = 0; i < n; i++) begin
            co.push_back(c);
            c += 1 + int'($urandom_range(max_gap, 0));
        end
    endtask

    task automatic add_body(inout logic [7:0] b[$]);
        logic [7:0] v;
        for (int i = 0; i < BODY_LEN; i++) begin
            v = 8'($urandom);
            if (v == 8'h4D) v = 8'h00;
            b.push_back(v);
        end
    endtask

    task automatic await_request(input int stall, output int r_cyc, output int gap);
        int got = 0, waited = 0, acc_r = -1, acc_nl = -1;
        r_cyc = -1;
        for (int i = 0; i < 4 * POLL_PERIOD && got < 2; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            bus.tx_ready = 1'b0;
            if (bus.tx_valid) begin
                if (r_cyc < 0) r_cyc = cyc;
                chk("busy_during_tx", 32'(bus.busy), 1);
                if (got == 0) begin
                    chk("tx_byte_R", 32'(bus.tx_data), 32'h52);
                    if (waited >= stall) begin
                        bus.tx_ready = 1'b1;
                        got = 1;
                        acc_r = cyc;
                    end else begin
                        waited++;
                    end
                end else begin
                    chk("tx_byte_NL", 32'(bus.tx_data), 32'h0A);
                    bus.tx_ready = 1'b1;
                    got = 2;
                    acc_nl = cyc;
                end
            end else if (r_cyc >= 0) begin
                chk("tx_valid_held", 0, 1);
            end
        end
        if (got < 2) chk("request_seen", got, 2);
        gap = acc_nl - acc_r;
    endtask

    task automatic observe(input logic [7:0] b[$], input int co[$], input int exp_done,
                           input int exp_tmo, input int drop_en);
        int fd_c = -1, fd_n = 0, te_c = -1, te_n = 0, j = 0;
        int last = (exp_done < 0) ? TIMEOUT : TIMEOUT + 1;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            bus.tx_ready = 1'b0;
            if (c == drop_en) bus.enable = 1'b0;
            if (bus.frame_done) begin
                fd_n++;
                if (fd_c < 0) fd_c = c;
            end
            if (bus.timeout_err) begin
                te_n++;
                if (te_c < 0) te_c = c;
            end
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'h00;
            if (j < b.size() && co[j] == c) begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = b[j];
                j++;
            end
        end
        chk("frame_done_cycle", fd_c, exp_done);
        chk("frame_done_pulses", fd_n, (exp_done >= 0) ? 1 : 0);
        chk("timeout_err_cycle", te_c, exp_tmo);
        chk("timeout_err_pulses", te_n, (exp_tmo >= 0) ? 1 : 0);
        chk("err_cnt", 32'(bus.err_cnt), exp_err);
    endtask

    task automatic run_poll(input logic [7:0] b[$], input int co[$], input int exp_done,
                            input int stall, input int drop_en, output int r_cyc, output int gap);
        logic [7:0] none_b[$];
        int         none_c[$];
        int         rc, g, ed, et;
        r_cyc = -1;
        gap   = -1;
        for (int a = 0; a <= N_RETRY; a++) begin
            await_request(stall, rc, g);
            if (a == 0) begin
                r_cyc = rc;
                gap   = g;
            end
            ed = (a == 0) ? exp_done : -1;
            et = (ed < 0 && a == N_RETRY) ? TIMEOUT : -1;
            if (et >= 0 && exp_err < 255) exp_err++;
            if (a == 0) observe(b, co, ed, et, drop_en);
            else        observe(none_b, none_c, ed, et, -1);
            if (ed >= 0) break;
        end
    endtask

    initial begin
        hdr_vec_t   tbl[8];
        logic [7:0] b[$];
        int         co[$];
        int         r1, r2, g, cnt;
        string      s;

        tbl[0] = '{pat: "MEAS",    done: 1'b1};
        tbl[1] = '{pat: "MMEAS",   done: 1'b1};
        tbl[2] = '{pat: "MEXMEAS", done: 1'b1};
        tbl[3] = '{pat: "MEAXS",   done: 1'b0};
        tbl[4] = '{pat: "XXMEAS",  done: 1'b1};
        tbl[5] = '{pat: "MEMEAS",  done: 1'b1};
        tbl[6] = '{pat: "SAEM",    done: 1'b0};
        tbl[7] = '{pat: "MEA",     done: 1'b0};

        bus.enable   = 1'b0;
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", 32'(bus.tx_valid), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 0);
        reset_n = 1'b1;
        @(negedge clk);
        bus.enable = 1'b1;

        // Basic request/reply, back-to-back TX bytes, poll period.
        b = {8'h4D, 8'h45, 8'h41, 8'h53};
        add_body(b);
        sched(b.size(), 0, co);
        run_poll(b, co, 4 + BODY_LEN, 0, -1, r1, g);
        chk("tx_bytes_consecutive", g, 1);
        run_poll(b, co, 4 + BODY_LEN, 0, -1, r2, g);
        chk("poll_period", r2 - r1, POLL_PERIOD);

        // Header matcher patterns, bytes on consecutive cycles.
        foreach (tbl[i]) begin
            s = tbl[i].pat;
            b = {};
            for (int k = 0; k < s.len(); k++) b.push_back(8'(s[k]));
            add_body(b);
            sched(b.size(), 0, co);
            run_poll(b, co, tbl[i].done ? s.len() + BODY_LEN : -1, 0, -1, r1, g);
        end

        // Last body byte one cycle before, and exactly at, the timeout cycle.
        b = {8'h4D, 8'h45, 8'h41, 8'h53};
        add_body(b);
        sched(b.size() - 1, 0, co);
        co.push_back(TIMEOUT - 2);
        run_poll(b, co, TIMEOUT - 1, 0, -1, r1, g);
        co[co.size()-1] = TIMEOUT - 1;
        run_poll(b, co, -1, 0, -1, r1, g);

        // No reply at all.
        b = {};
        co = {};
        run_poll(b, co, -1, 0, -1, r1, g);

        // TX stall in SEND_R, then enable dropped mid-body.
        b = {8'h4D, 8'h45, 8'h41, 8'h53};
        add_body(b);
        sched(b.size(), 0, co);
        run_poll(b, co, 4 + BODY_LEN, 10, 10, r1, g);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.tx_valid) cnt++;
        end
        chk("no_request_when_disabled", cnt, 0);
        chk("idle_busy", 32'(bus.busy), 0);
        bus.enable = 1'b1;

        // Randomized replies against the reference model.
        for (int n = 0; n < 12; n++) begin
            b = {};
            for (int k = 0; k < int'($urandom_range(6, 0)); k++) begin
                case ($urandom_range(4, 0))
                    0: b.push_back(8'h4D);
                    1: b.push_back(8'h45);
                    2: b.push_back(8'h41);
                    3: b.push_back(8'h53);
                    default: b.push_back(8'h58);
                endcase
            end
            if ($urandom_range(4, 0) != 0) b = {b, 8'h4D, 8'h45, 8'h41, 8'h53};
            else                           b = {b, 8'h4D, 8'h45, 8'h53};
            for (int k = 0; k < BODY_LEN; k++) b.push_back(8'($urandom));
            sched(b.size(), int'($urandom_range(3, 0)), co);
            run_poll(b, co, model_done(b, co), int'($urandom_range(3, 0)), -1, r1, g);
        end

        // Drive err_cnt into saturation.
        b = {};
        co = {};
        while (exp_err < 255) run_poll(b, co, -1, 0, -1, r1, g);
        run_poll(b, co, -1, 0, -1, r1, g);
        run_poll(b, co, -1, 0, -1, r1, g);
        chk("err_cnt_saturated", 32'(bus.err_cnt), 32'hFF);

        // Asynchronous reset while the newline byte is pending.
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 4 * POLL_PERIOD && !(bus.tx_valid && bus.tx_data == 8'h0A); i++) begin
            @(negedge clk);
            bus.tx_ready = bus.tx_valid && (bus.tx_data == 8'h52);
        end
        chk("reached_send_nl", 32'(bus.tx_data), 32'h0A);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_tx_valid", 32'(bus.tx_valid), 0);
        chk("arst_tx_data", 32'(bus.tx_data), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_frame_done", 32'(bus.frame_done), 0);
        chk("arst_timeout_err", 32'(bus.timeout_err), 0);
        chk("arst_err_cnt", 32'(bus.err_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
